// File: rtl/coeff_pkg.sv
// Shared types and helpers for the FIR coefficient bank store.
// Folding maps the upper half of a symmetric tap index onto its mirrored lower half.
package coeff_pkg;

  typedef enum logic {IDLE, PENDING} swap_state_e;

  localparam int CoeffWidth = 16;
  typedef logic signed [CoeffWidth-1:0] coeff_t;

  function automatic int depth_f(input int taps, input bit symmetric);
    return symmetric ? (taps + 1) / 2 : taps;
  endfunction

  function automatic int fold_addr_f(input int addr, input int taps, input bit symmetric);
    int depth;
    depth = depth_f(taps, symmetric);
    return (addr < depth) ? addr : taps - 1 - addr;
  endfunction

endpackage

// File: rtl/coeff_swap_ctrl.sv
// Active-bank swap FSM: a requested bank is committed on the next frame strobe.
// Also owns write protection of the active and pending banks.
module coeff_swap_ctrl
  import coeff_pkg::*;
#(
  parameter int BW = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          swap_req_i,
  input  logic [BW-1:0] swap_bank_i,
  input  logic          frame_start_i,
  input  logic [BW-1:0] wbank_i,
  output logic [BW-1:0] active_bank_o,
  output logic          swap_done_o,
  output logic          wready_o
);

  swap_state_e   r_state;
  logic [BW-1:0] r_pend;
  logic [BW-1:0] r_active;
  logic          r_swap_done;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_pend      <= '0;
      r_active    <= '0;
      r_swap_done <= 1'b0;
    end else begin
      r_swap_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // A strobe coinciding with the entering request is deliberately ignored.
          if (swap_req_i) begin
            r_pend  <= swap_bank_i;
            r_state <= PENDING;
          end
        end
        PENDING: begin
          if (frame_start_i) begin
            r_active    <= swap_req_i ? swap_bank_i : r_pend;
            r_swap_done <= 1'b1;
            r_state     <= IDLE;
          end else if (swap_req_i) begin
            r_pend <= swap_bank_i;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wready_o      = !(wbank_i == r_active) && !(r_state == PENDING && wbank_i == r_pend);
  assign active_bank_o = r_active;
  assign swap_done_o   = r_swap_done;

endmodule

// File: rtl/coeff_bank_lut.sv
// Multi-bank FIR coefficient store with symmetric folding; one read per cycle, 1-cycle latency.
// Writes to the active or pending bank are refused via wready_o; out-of-range writes pulse wr_err_o.
module coeff_bank_lut
  import coeff_pkg::*;
#(
  parameter int DataWidth = 16,
  parameter int Taps      = 101,
  parameter int NumBanks  = 4,
  parameter int Symmetric = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        ren_i,
  input  logic [$clog2(Taps)-1:0]     addr_i,
  output logic signed [DataWidth-1:0] data_o,
  output logic                        valid_o,
  input  logic                        wvalid_i,
  output logic                        wready_o,
  input  logic [$clog2(NumBanks)-1:0] wbank_i,
  input  logic [$clog2(Taps)-1:0]     waddr_i,
  input  logic [DataWidth-1:0]        wdata_i,
  output logic                        wr_err_o,
  input  logic                        swap_req_i,
  input  logic [$clog2(NumBanks)-1:0] swap_bank_i,
  input  logic                        frame_start_i,
  output logic                        swap_done_o,
  output logic [$clog2(NumBanks)-1:0] active_bank_o
);

  localparam int BW    = $clog2(NumBanks);
  localparam int Depth = depth_f(Taps, Symmetric != 0);
  localparam int PW    = (Depth > 1) ? $clog2(Depth) : 1;

  logic signed [DataWidth-1:0] r_mem [NumBanks][Depth];
  logic signed [DataWidth-1:0] r_data;
  logic                        r_valid;
  logic                        r_wr_err;

  logic [BW-1:0] w_active;
  logic [PW-1:0] w_phys;
  logic          w_rd_ok;
  logic          w_wr_ok;
  logic          w_wr_fire;

  coeff_swap_ctrl #(.BW(BW)) u_swap (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .swap_req_i    (swap_req_i),
    .swap_bank_i   (swap_bank_i),
    .frame_start_i (frame_start_i),
    .wbank_i       (wbank_i),
    .active_bank_o (w_active),
    .swap_done_o   (swap_done_o),
    .wready_o      (wready_o)
  );

  assign w_phys    = PW'(fold_addr_f(int'(addr_i), Taps, Symmetric != 0));
  assign w_rd_ok   = int'(addr_i) < Taps;
  assign w_wr_ok   = int'(waddr_i) < Depth;
  assign w_wr_fire = wvalid_i && wready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NumBanks; b++) begin
        for (int w = 0; w < Depth; w++) begin
          r_mem[b][w] <= '0;
        end
      end
    end else if (w_wr_fire && w_wr_ok) begin
      r_mem[wbank_i][waddr_i[PW-1:0]] <= wdata_i;
    end
  end

  // Reads see the pre-edge array and bank, so same-edge writes/swaps are not visible yet.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_valid  <= ren_i;
      r_wr_err <= w_wr_fire && !w_wr_ok;
      if (ren_i) begin
        r_data <= w_rd_ok ? r_mem[w_active][w_phys] : '0;
      end
    end
  end

  assign data_o        = r_data;
  assign valid_o       = r_valid;
  assign wr_err_o      = r_wr_err;
  assign active_bank_o = w_active;

endmodule

// File: tb/tb_coeff_bank_lut.sv
// Directed bench for coeff_bank_lut with a read scoreboard (Taps=19, Depth=10).
module tb_coeff_bank_lut;
  import coeff_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ren_i;
  logic [4:0]  addr_i;
  logic signed [15:0] data_o;
  logic        valid_o;
  logic        wvalid_i;
  logic        wready_o;
  logic [1:0]  wbank_i;
  logic [4:0]  waddr_i;
  logic [15:0] wdata_i;
  logic        wr_err_o;
  logic        swap_req_i;
  logic [1:0]  swap_bank_i;
  logic        frame_start_i;
  logic        swap_done_o;
  logic [1:0]  active_bank_o;

  int n_vec = 0;
  int n_err = 0;
  coeff_t exp_q[$];

  coeff_bank_lut #(.DataWidth(16), .Taps(19), .NumBanks(4), .Symmetric(1)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .ren_i         (ren_i),
    .addr_i        (addr_i),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .wvalid_i      (wvalid_i),
    .wready_o      (wready_o),
    .wbank_i       (wbank_i),
    .waddr_i       (waddr_i),
    .wdata_i       (wdata_i),
    .wr_err_o      (wr_err_o),
    .swap_req_i    (swap_req_i),
    .swap_bank_i   (swap_bank_i),
    .frame_start_i (frame_start_i),
    .swap_done_o   (swap_done_o),
    .active_bank_o (active_bank_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input coeff_t e);
    ren_i  = 1'b1;
    addr_i = a;
    exp_q.push_back(e);
    tick();
  endtask

  task automatic wr(input logic [1:0] b, input logic [4:0] a, input logic [15:0] d);
    wvalid_i = 1'b1;
    wbank_i  = b;
    waddr_i  = a;
    wdata_i  = d;
    tick();
    wvalid_i = 1'b0;
  endtask

  task automatic swap_to(input logic [1:0] b);
    swap_req_i  = 1'b1;
    swap_bank_i = b;
    tick();
    swap_req_i    = 1'b0;
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
  endtask

  // Read scoreboard: every valid_o pops one expected coefficient.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 32'(valid_o), 32'd0);
      end else begin
        chk("rd_data", 32'(data_o), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst_ni = 1'b0; ren_i = 1'b0; addr_i = '0; wvalid_i = 1'b0; wbank_i = '0;
    waddr_i = '0; wdata_i = '0; swap_req_i = 1'b0; swap_bank_i = '0; frame_start_i = 1'b0;
    #12;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_active", 32'(active_bank_o), 32'd0);
    chk("rst_swap_done", 32'(swap_done_o), 32'd0);
    chk("rst_wr_err", 32'(wr_err_o), 32'd0);
    chk("rst_wready_b0", 32'(wready_o), 32'd0);
    wbank_i = 2'd1; #1;
    chk("rst_wready_b1", 32'(wready_o), 32'd1);
    tick();
    rst_ni = 1'b1;
    tick();

    rd(5'd5, 16'sd0);
    ren_i = 1'b0;
    chk("rd_valid", 32'(valid_o), 32'd1);

    wbank_i = 2'd1; #1;
    chk("wready_inactive", 32'(wready_o), 32'd1);
    wr(2'd1, 5'd9, 16'h7fff);
    wr(2'd1, 5'd0, 16'h02d9);

    wbank_i = 2'd0; #1;
    chk("wready_active", 32'(wready_o), 32'd0);
    wr(2'd0, 5'd3, 16'h1234);
    rd(5'd3, 16'sd0);
    rd(5'd15, 16'sd0);
    ren_i = 1'b0;

    // Request and strobe together: swap must wait for the next strobe.
    swap_req_i = 1'b1; swap_bank_i = 2'd1; frame_start_i = 1'b1;
    tick();
    swap_req_i = 1'b0; frame_start_i = 1'b0;
    chk("same_cycle_active", 32'(active_bank_o), 32'd0);
    chk("same_cycle_done", 32'(swap_done_o), 32'd0);
    wbank_i = 2'd1; #1;
    chk("wready_pending", 32'(wready_o), 32'd0);
    tick();
    chk("pend_active", 32'(active_bank_o), 32'd0);

    frame_start_i = 1'b1;
    rd(5'd0, 16'sd0);
    frame_start_i = 1'b0;
    chk("swap_active", 32'(active_bank_o), 32'd1);
    chk("swap_done", 32'(swap_done_o), 32'd1);
    rd(5'd0, 16'sh02d9);
    chk("swap_done_pulse", 32'(swap_done_o), 32'd0);
    rd(5'd9, 16'sh7fff);
    rd(5'd18, 16'sh02d9);
    rd(5'd19, 16'sd0);
    rd(5'd10, 16'sd0);
    ren_i = 1'b0;

    wr(2'd2, 5'd4, 16'h0abc);
    wbank_i = 2'd1; #1;
    chk("wready_active_b1", 32'(wready_o), 32'd0);
    wr(2'd1, 5'd9, 16'h1111);
    rd(5'd9, 16'sh7fff);
    ren_i = 1'b0;

    swap_req_i = 1'b1; swap_bank_i = 2'd2;
    tick();
    swap_req_i = 1'b0;
    wbank_i = 2'd2; #1;
    chk("wready_pend_b2", 32'(wready_o), 32'd0);
    wr(2'd2, 5'd1, 16'h5555);
    swap_req_i = 1'b1; swap_bank_i = 2'd1;
    tick();
    swap_bank_i = 2'd3;
    tick();
    swap_req_i = 1'b0;
    wbank_i = 2'd2; #1;
    chk("wready_b2_released", 32'(wready_o), 32'd1);
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
    chk("latest_wins", 32'(active_bank_o), 32'd3);
    chk("latest_done", 32'(swap_done_o), 32'd1);

    wbank_i = 2'd0; waddr_i = 5'd12; #1;
    chk("wready_err", 32'(wready_o), 32'd1);
    wr(2'd0, 5'd12, 16'h7777);
    chk("wr_err_pulse", 32'(wr_err_o), 32'd1);
    tick();
    chk("wr_err_clear", 32'(wr_err_o), 32'd0);

    swap_to(2'd2);
    chk("swap_b2", 32'(active_bank_o), 32'd2);
    rd(5'd4, 16'sh0abc);
    rd(5'd1, 16'sd0);
    rd(5'd14, 16'sh0abc);
    ren_i = 1'b0;
    tick();
    tick();
    chk("hold_data", 32'(data_o), 32'h0abc);
    chk("hold_valid", 32'(valid_o), 32'd0);

    swap_req_i = 1'b1; swap_bank_i = 2'd1;
    tick();
    swap_req_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #2;
    chk("mid_rst_active", 32'(active_bank_o), 32'd0);
    chk("mid_rst_data", 32'(data_o), 32'd0);
    chk("mid_rst_valid", 32'(valid_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    wbank_i = 2'd1; #1;
    chk("mid_rst_idle", 32'(wready_o), 32'd1);
    tick();
    chk("mid_rst_no_swap", 32'(active_bank_o), 32'd0);
    swap_to(2'd1);
    chk("post_rst_swap", 32'(active_bank_o), 32'd1);
    rd(5'd9, 16'sd0);
    rd(5'd0, 16'sd0);
    ren_i = 1'b0;
    tick();
    tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/coeff_bank_lut.md
# coeff_bank_lut

Multi-bank, runtime-loadable FIR coefficient store for the filter datapath in the ultrasound compression chain. It holds `NumBanks` coefficient sets (HPF, LPF, band-pass, …), each loaded through a write handshake. Symmetric linear-phase sets are folded, so only half of each set is stored. The active bank changes only at a frame boundary, so a filter pass never mixes two coefficient sets. It feeds the FIR MAC one coefficient per read with a single cycle of latency.

## Interface
Parameters:
- `DataWidth`, 16, coefficient width in bits, two's complement.
- `Taps`, 101, filter length.
- `NumBanks`, 4, number of coefficient sets.
- `Symmetric`, 1, when 1, stores `Depth = (Taps+1)/2` words per bank; when 0, stores `Depth = Taps` words per bank.

Ports:
- `clk_i`, in, 1, clock.
- `rst_ni`, in, 1, asynchronous active-low reset.
- `ren_i`, in, 1, read enable.
- `addr_i`, in, `$clog2(Taps)`, tap index.
- `data_o`, out, `DataWidth`, coefficient, signed.
- `valid_o`, out, 1, `data_o` updated this cycle.
- `wvalid_i`, in, 1, write request.
- `wready_o`, out, 1, write accepted.
- `wbank_i`, in, `$clog2(NumBanks)`, target bank.
- `waddr_i`, in, `$clog2(Taps)`, physical word index.
- `wdata_i`, in, `DataWidth`, coefficient.
- `wr_err_o`, out, 1, pulse when a write is discarded because the address is out of range.
- `swap_req_i`, in, 1, request activation of a bank.
- `swap_bank_i`, in, `$clog2(NumBanks)`, bank to activate.
- `frame_start_i`, in, 1, frame-boundary strobe from the sequencer.
- `swap_done_o`, out, 1, pulse when the active bank has been updated.
- `active_bank_o`, out, `$clog2(NumBanks)`, currently active bank.

Clocking and reset: reset `rst_ni` is asynchronous and active-low; the clock is `clk_i`.

## Operation
- **Storage:** a flop array of `NumBanks × Depth` words. All words reset to 0.
- **Read address fold (Symmetric=1):**
  - phys = `addr_i` when `addr_i < Depth`.
  - phys = `Taps-1-addr_i` otherwise.
- **Out-of-range read:** `addr_i ≥ Taps` returns 0 with `valid_o` still asserted.
- **Read:** uses the active bank as it stands at the sampling edge.
- **Hold:** `data_o` holds its value while `ren_i` is low.
- **Write protection:** `wready_o = !(wbank_i == active) && !(state == PENDING && wbank_i == pend_bank)`.
  - `wready_o` is combinational from `wbank_i`.
  - A write is performed on `wvalid_i && wready_o`.
- **Out-of-range write:** a handshake with `waddr_i ≥ Depth` writes nothing and pulses `wr_err_o` for one cycle.
- **Swap FSM, two states:**
  - IDLE, on `swap_req_i`: latch `pend_bank ← swap_bank_i` and go to PENDING.
  - PENDING, on `swap_req_i`: overwrite `pend_bank` (latest request wins).
  - PENDING, on `frame_start_i`: `active ← pend_bank`, pulse `swap_done_o`, return to IDLE.
- **Swap boundary cases:**
  - A `frame_start_i` in the same cycle as the request that enters PENDING is ignored; the swap waits for the next strobe.
  - A swap to the already-active bank completes normally, including the `swap_done_o` pulse.
- **Reset mid-operation:** FSM returns to IDLE, `pend_bank` and `active` become 0, and the table is cleared to 0.

## Timing
- **Read latency:** 1 cycle from the `ren_i` edge to `data_o`/`valid_o`.
- **Read throughput:** one read per cycle.
- **Write:** takes effect on the handshake edge. A read of the same word in the following cycle sees the new value.
- **Same-edge read and write:** a read in the same cycle as a write to the same word returns the old value. This only applies to inactive banks, because the active bank cannot be written.
- **Swap:** `active_bank_o` and `swap_done_o` update on the edge that samples `frame_start_i` in PENDING.
  - A read sampled on that same edge uses the old bank.
  - The first read using the new bank is sampled in the following cycle.
- **Reset values:** `data_o = 0`, `valid_o = 0`, `wr_err_o = 0`, `swap_done_o = 0`, `active_bank_o = 0`. `wready_o = (wbank_i != 0)`.

## Structure
- **Shared package `coeff_pkg`:**
  - Swap-state enum `{IDLE, PENDING}`.
  - `coeff_t` typedef (`logic signed [DataWidth-1:0]`).
  - Functions `depth_f(Taps, Symmetric)` and `fold_addr_f`.
- **Sub-module `coeff_swap_ctrl`:** the swap FSM, owning `active`, `pend_bank`, `swap_done_o` and the write-protect compare.
- **Top level:** holds the storage array, the fold logic and the output register.

## Test plan
- **Reset state:** after reset, a read at `addr_i = 5` returns 0 with `valid_o = 1` one cycle later, and `active_bank_o = 0`.
- **Write/read with symmetric fold:** with `Taps = 19`, load bank 1 word 9 with `16'h7fff` and word 0 with `16'h02d9`. Swap to bank 1 at `frame_start_i`.
  - Reads of 0, 9, 18 return `02d9`, `7fff`, `02d9`.
  - A read of `addr_i = 19` returns 0.
- **Write protection:** a write to active bank 0 keeps `wready_o` low and the stored value unchanged. A write to bank 2 while bank 2 is pending is blocked the same way.
- **Swap boundary:**
  - `swap_req_i` and `frame_start_i` in the same cycle leave the active bank unchanged.
  - The next `frame_start_i` switches the bank and pulses `swap_done_o`.
  - A read on the swap edge returns the old bank's value.
- **Latest request wins:** requests for bank 1 then bank 3 while PENDING, followed by `frame_start_i`, give `active_bank_o = 3`.
- **Error and reset:**
  - A write with `waddr_i = 12` when `Depth = 10` pulses `wr_err_o` and writes nothing.
  - Asserting `rst_ni` low in PENDING clears the FSM to IDLE, `active_bank_o` to 0 and the table to 0.
